// File: rtl/vend_pkg.sv
// Shared constants for the vending controller: default widths and FSM state codes.
// Optional payment timeout is enabled with VEND_TIMEOUT_EN (see vend_controller).
package vend_pkg;

    localparam int unsigned ITEM_ADDR_WIDTH_DFLT = 10;
    localparam int unsigned AMT_WIDTH_DFLT       = 12;
    localparam int unsigned ST_WIDTH             = 3;

    localparam logic [ST_WIDTH-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_WIDTH-1:0] ST_LOOKUP   = 3'd1;
    localparam logic [ST_WIDTH-1:0] ST_PAY      = 3'd2;
    localparam logic [ST_WIDTH-1:0] ST_DISPENSE = 3'd3;
    localparam logic [ST_WIDTH-1:0] ST_CHANGE   = 3'd4;

endpackage

// File: rtl/vend_if.sv
// Bundle of selection, price-table, coin, dispense and change signals around the controller.
// timeout_evt exists only when VEND_TIMEOUT_EN is defined.
interface vend_if
    import vend_pkg::*;
#(
    parameter int unsigned ITEM_ADDR_WIDTH = ITEM_ADDR_WIDTH_DFLT,
    parameter int unsigned AMT_WIDTH       = AMT_WIDTH_DFLT
);
    logic [ITEM_ADDR_WIDTH-1:0] selected_item;
    logic                       selection_ready;
    logic                       price_req;
    logic [ITEM_ADDR_WIDTH-1:0] price_addr;
    logic                       price_valid;
    logic [AMT_WIDTH-1:0]       price_data;
    logic                       price_sold_out;
    logic                       coin_valid;
    logic [AMT_WIDTH-1:0]       coin_value;
    logic                       cancel;
    logic                       dispense_valid;
    logic [ITEM_ADDR_WIDTH-1:0] dispense_item;
    logic                       dispense_ack;
    logic                       change_valid;
    logic [AMT_WIDTH-1:0]       change_amount;
    logic                       change_ack;
    logic [AMT_WIDTH-1:0]       credit;
    logic                       busy;
    logic                       sold_out;
`ifdef VEND_TIMEOUT_EN
    logic                       timeout_evt;
`endif

    modport master (
        input  selected_item, selection_ready, price_valid, price_data, price_sold_out,
               coin_valid, coin_value, cancel, dispense_ack, change_ack,
        output price_req, price_addr, dispense_valid, dispense_item, change_valid,
               change_amount, credit, busy, sold_out
`ifdef VEND_TIMEOUT_EN
        , output timeout_evt
`endif
    );

    modport slave (
        output selected_item, selection_ready, price_valid, price_data, price_sold_out,
               coin_valid, coin_value, cancel, dispense_ack, change_ack,
        input  price_req, price_addr, dispense_valid, dispense_item, change_valid,
               change_amount, credit, busy, sold_out
`ifdef VEND_TIMEOUT_EN
        , input timeout_evt
`endif
    );

endinterface

// File: rtl/vend_credit_acc.sv
// Saturating credit register with clear/add and a combinational "updated credit covers price" flag.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int unsigned AMT_WIDTH = AMT_WIDTH_DFLT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 add_en,
    input  logic [AMT_WIDTH-1:0] add_val,
    input  logic [AMT_WIDTH-1:0] price,
    output logic [AMT_WIDTH-1:0] credit,
    output logic [AMT_WIDTH-1:0] credit_upd_c,
    output logic                 covers_c
);

    logic [AMT_WIDTH-1:0] addend_c;
    logic [AMT_WIDTH:0]   sum_c;

    // Credit including this cycle's coin, clamped at all-ones.
    always_comb begin
        addend_c     = add_en ? add_val : '0;
        sum_c        = {1'b0, credit} + {1'b0, addend_c};
        credit_upd_c = sum_c[AMT_WIDTH] ? '1 : sum_c[AMT_WIDTH-1:0];
        covers_c     = (credit_upd_c >= price);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         credit <= '0;
        else if (clr)    credit <= '0;
        else if (add_en) credit <= credit_upd_c;
    end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: price lookup, coin payment, dispense and change/refund handshakes.
// Define VEND_TIMEOUT_EN to add the PAY inactivity auto-refund and the timeout_evt output.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned ITEM_ADDR_WIDTH = ITEM_ADDR_WIDTH_DFLT,
    parameter int unsigned AMT_WIDTH       = AMT_WIDTH_DFLT
`ifdef VEND_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic   clk,
    input  logic   rst,
    vend_if.master bus
);

    logic [ST_WIDTH-1:0]        state_q, state_d;
    logic [ITEM_ADDR_WIDTH-1:0] item_q, item_d;
    logic [AMT_WIDTH-1:0]       price_q, price_d;
    logic [AMT_WIDTH-1:0]       chg_q, chg_d;
    logic                       price_req_q, price_req_d;
    logic                       sold_q, sold_d;
    logic                       dv_q, cv_q, busy_q;
    logic                       acc_clr, acc_add, abort_c, covers_c;
    logic [AMT_WIDTH-1:0]       credit, credit_upd_c;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TMR_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_WIDTH-1:0] tmr_q, tmr_d;
    logic                 tmo_q, tmo_d, expired_c;
`endif

    vend_credit_acc #(.AMT_WIDTH(AMT_WIDTH)) u_acc (
        .clk          (clk),
        .rst          (rst),
        .clr          (acc_clr),
        .add_en       (acc_add),
        .add_val      (bus.coin_value),
        .price        (price_q),
        .credit       (credit),
        .credit_upd_c (credit_upd_c),
        .covers_c     (covers_c)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        item_d      = item_q;
        price_d     = price_q;
        chg_d       = chg_q;
        price_req_d = 1'b0;
        sold_d      = 1'b0;
        acc_clr     = 1'b0;
        acc_add     = 1'b0;
        abort_c     = 1'b0;
`ifdef VEND_TIMEOUT_EN
        tmr_d       = tmr_q;
        tmo_d       = 1'b0;
        expired_c   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                acc_add = bus.coin_valid;
                if (bus.selection_ready) begin
                    item_d      = bus.selected_item;
                    price_req_d = 1'b1;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                acc_add = bus.coin_valid;
                if (bus.price_valid) begin
                    if (bus.price_sold_out) begin
                        sold_d = 1'b1;
                        if (credit_upd_c != '0) begin
                            chg_d   = credit_upd_c;
                            state_d = ST_CHANGE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        price_d = bus.price_data;
                        state_d = ST_PAY;
`ifdef VEND_TIMEOUT_EN
                        tmr_d   = '0;
`endif
                    end
                end
            end
            ST_PAY: begin
                acc_add = bus.coin_valid;
`ifdef VEND_TIMEOUT_EN
                expired_c = !bus.coin_valid && (tmr_q == TMR_WIDTH'(TIMEOUT_CYCLES - 1));
                tmr_d     = bus.coin_valid ? '0 : tmr_q + 1'b1;
                tmo_d     = expired_c;
                abort_c   = bus.cancel | expired_c;
`else
                abort_c   = bus.cancel;
`endif
                // Cancel wins over a covering coin; the coin is still refunded.
                if (abort_c) begin
                    if (credit_upd_c != '0) begin
                        chg_d   = credit_upd_c;
                        state_d = ST_CHANGE;
                    end else begin
                        acc_clr = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (covers_c) begin
                    chg_d   = credit_upd_c - price_q;
                    state_d = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (bus.dispense_ack) begin
                    if (chg_q != '0) begin
                        state_d = ST_CHANGE;
                    end else begin
                        acc_clr = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CHANGE: begin
                if (bus.change_ack) begin
                    acc_clr = 1'b1;
                    chg_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            item_q      <= '0;
            price_q     <= '0;
            chg_q       <= '0;
            price_req_q <= 1'b0;
            sold_q      <= 1'b0;
            dv_q        <= 1'b0;
            cv_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_q      <= item_d;
            price_q     <= price_d;
            chg_q       <= chg_d;
            price_req_q <= price_req_d;
            sold_q      <= sold_d;
            dv_q        <= (state_d == ST_DISPENSE);
            cv_q        <= (state_d == ST_CHANGE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

`ifdef VEND_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.timeout_evt = tmo_q;
`endif

    assign bus.price_req      = price_req_q;
    assign bus.price_addr     = item_q;
    assign bus.dispense_valid = dv_q;
    assign bus.dispense_item  = item_q;
    assign bus.change_valid   = cv_q;
    assign bus.change_amount  = chg_q;
    assign bus.credit         = credit;
    assign bus.busy           = busy_q;
    assign bus.sold_out       = sold_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed test-plan cases plus random transactions
// checked against a transaction-level model. Timeout cases run when VEND_TIMEOUT_EN is defined.
module tb_vend_controller;

    localparam int unsigned IW      = 10;
    localparam int unsigned AW      = 8;
    localparam int          AMT_MAX = (1 << AW) - 1;
`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO      = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_if #(.ITEM_ADDR_WIDTH(IW), .AMT_WIDTH(AW)) bus ();

    vend_controller #(
        .ITEM_ADDR_WIDTH(IW),
        .AMT_WIDTH(AW)
`ifdef VEND_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_credit;
    int cur_item;
    int cur_price;
    bit txn_done;
    int coin_tbl [5] = '{5, 10, 25, 50, 100};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int a);
        return (a > AMT_MAX) ? AMT_MAX : a;
    endfunction

    task automatic ack_change(input int amt);
        int d;
        d = $urandom_range(0, 3);
        repeat (d) begin
            bus.dispense_ack = 1'($urandom_range(0, 1));
            tick();
            chk("change_hold_valid", 32'(bus.change_valid), 1);
            chk("change_hold_amount", 32'(bus.change_amount), amt);
        end
        bus.dispense_ack = 1'b0;
        bus.change_ack   = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        chk("change_drop", 32'(bus.change_valid), 0);
        chk("change_idle_busy", 32'(bus.busy), 0);
        chk("change_credit_clear", 32'(bus.credit), 0);
        exp_credit = 0;
        txn_done   = 1'b1;
    endtask

    task automatic finish_dispense();
        int chg;
        int d;
        chg = exp_credit - cur_price;
        chk("dispense_item", 32'(bus.dispense_item), cur_item);
        d = $urandom_range(0, 3);
        repeat (d) begin
            bus.change_ack = 1'($urandom_range(0, 1));
            tick();
            chk("dispense_hold_valid", 32'(bus.dispense_valid), 1);
            chk("dispense_hold_item", 32'(bus.dispense_item), cur_item);
        end
        bus.change_ack   = 1'b0;
        bus.dispense_ack = 1'b1;
        tick();
        bus.dispense_ack = 1'b0;
        chk("dispense_drop", 32'(bus.dispense_valid), 0);
        if (chg > 0) begin
            chk("overpay_change_valid", 32'(bus.change_valid), 1);
            chk("overpay_change_amount", 32'(bus.change_amount), chg);
            ack_change(chg);
        end else begin
            chk("exact_no_change", 32'(bus.change_valid), 0);
            chk("exact_idle_busy", 32'(bus.busy), 0);
            chk("exact_credit_clear", 32'(bus.credit), 0);
            exp_credit = 0;
            txn_done   = 1'b1;
        end
    endtask

    task automatic coin_idle(input int v);
        bus.coin_valid = 1'b1;
        bus.coin_value = AW'(v);
        tick();
        bus.coin_valid = 1'b0;
        exp_credit = sat(exp_credit + v);
        chk("prepay_credit", 32'(bus.credit), exp_credit);
        chk("prepay_busy", 32'(bus.busy), 0);
    endtask

    task automatic select(input int it);
        txn_done             = 1'b0;
        bus.selected_item    = IW'(it);
        bus.selection_ready  = 1'b1;
        tick();
        bus.selection_ready = 1'b0;
        cur_item = it;
        chk("price_req_rise", 32'(bus.price_req), 1);
        chk("price_addr", 32'(bus.price_addr), it);
        chk("lookup_busy", 32'(bus.busy), 1);
        tick();
        chk("price_req_pulse", 32'(bus.price_req), 0);
    endtask

    task automatic respond(input int price, input bit sold, input int lat);
        repeat (lat) begin
            bus.selection_ready = 1'($urandom_range(0, 1));
            bus.selected_item   = IW'($urandom);
            tick();
        end
        bus.selection_ready = 1'b0;
        bus.price_valid     = 1'b1;
        bus.price_data      = AW'(price);
        bus.price_sold_out  = sold;
        tick();
        bus.price_valid    = 1'b0;
        bus.price_sold_out = 1'b0;
        cur_price = price;
        chk("no_early_dispense", 32'(bus.dispense_valid), 0);
        if (sold) begin
            chk("sold_out_pulse", 32'(bus.sold_out), 1);
            if (exp_credit > 0) begin
                chk("sold_refund_valid", 32'(bus.change_valid), 1);
                chk("sold_refund_amount", 32'(bus.change_amount), exp_credit);
                tick();
                chk("sold_out_one_cycle", 32'(bus.sold_out), 0);
                ack_change(exp_credit);
            end else begin
                chk("sold_idle_busy", 32'(bus.busy), 0);
                chk("sold_no_change", 32'(bus.change_valid), 0);
                tick();
                chk("sold_out_one_cycle", 32'(bus.sold_out), 0);
                txn_done = 1'b1;
            end
        end else begin
            chk("no_sold_out", 32'(bus.sold_out), 0);
            chk("pay_busy", 32'(bus.busy), 1);
            if (exp_credit >= price) begin
                tick();
                chk("prepaid_dispense", 32'(bus.dispense_valid), 1);
                finish_dispense();
            end
        end
    endtask

    task automatic pay_step(input int v, input bit can, input bit noise);
        bus.coin_valid      = (v != 0);
        bus.coin_value      = AW'(v);
        bus.cancel          = can;
        bus.selection_ready = noise;
        bus.selected_item   = IW'($urandom);
        tick();
        bus.coin_valid      = 1'b0;
        bus.cancel          = 1'b0;
        bus.selection_ready = 1'b0;
        if (v != 0) exp_credit = sat(exp_credit + v);
        chk("pay_credit", 32'(bus.credit), exp_credit);
        if (can) begin
            chk("cancel_no_dispense", 32'(bus.dispense_valid), 0);
            if (exp_credit > 0) begin
                chk("cancel_refund_valid", 32'(bus.change_valid), 1);
                chk("cancel_refund_amount", 32'(bus.change_amount), exp_credit);
                ack_change(exp_credit);
            end else begin
                chk("cancel_idle_busy", 32'(bus.busy), 0);
                txn_done = 1'b1;
            end
        end else if (exp_credit >= cur_price) begin
            chk("dispense_latency", 32'(bus.dispense_valid), 1);
            finish_dispense();
        end else begin
            chk("pay_wait_no_dispense", 32'(bus.dispense_valid), 0);
            chk("pay_wait_busy", 32'(bus.busy), 1);
        end
    endtask

    task automatic random_txn();
        int n_pre, price, v, steps;
        bit sold, can;
        n_pre = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        for (int i = 0; i < n_pre; i++) coin_idle(coin_tbl[$urandom_range(0, 4)]);
        price = $urandom_range(1, 250);
        sold  = ($urandom_range(0, 7) == 0);
        select($urandom_range(0, (1 << IW) - 1));
        respond(price, sold, $urandom_range(0, 3));
        steps = 0;
        while (!txn_done && steps < 200) begin
            steps++;
            if ($urandom_range(0, 2) == 0) begin
                pay_step(0, 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                v   = coin_tbl[$urandom_range(0, 4)];
                can = ($urandom_range(0, 9) == 0) && (sat(exp_credit + v) < price);
                if (can && $urandom_range(0, 1) == 0) v = 0;
                pay_step(v, can, 1'($urandom_range(0, 1)));
            end
        end
        if (!txn_done) chk("txn_cycle_budget", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst                  = 1'b1;
        bus.selected_item    = '0;
        bus.selection_ready  = 1'b0;
        bus.price_valid      = 1'b0;
        bus.price_data       = '0;
        bus.price_sold_out   = 1'b0;
        bus.coin_valid       = 1'b0;
        bus.coin_value       = '0;
        bus.cancel           = 1'b0;
        bus.dispense_ack     = 1'b0;
        bus.change_ack       = 1'b0;
        exp_credit           = 0;
        txn_done             = 1'b0;
        repeat (3) tick();
        chk("rst_price_req", 32'(bus.price_req), 0);
        chk("rst_dispense_valid", 32'(bus.dispense_valid), 0);
        chk("rst_change_valid", 32'(bus.change_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sold_out", 32'(bus.sold_out), 0);
        chk("rst_credit", 32'(bus.credit), 0);
        chk("rst_change_amount", 32'(bus.change_amount), 0);
`ifdef VEND_TIMEOUT_EN
        chk("rst_timeout_evt", 32'(bus.timeout_evt), 0);
`endif
        rst = 1'b0;
        tick();

        // exact pay, overpay, cancel, cancel with same-cycle coin
        select(5);  respond(150, 1'b0, 1); pay_step(100, 1'b0, 1'b0); pay_step(50, 1'b0, 1'b0);
        select(9);  respond(150, 1'b0, 0); pay_step(100, 1'b0, 1'b0); pay_step(100, 1'b0, 1'b0);
        select(3);  respond(200, 1'b0, 2); pay_step(100, 1'b0, 1'b0); pay_step(0, 1'b1, 1'b0);
        select(4);  respond(200, 1'b0, 1); pay_step(100, 1'b0, 1'b0); pay_step(50, 1'b1, 1'b0);

        // sold out with and without pre-paid credit
        select(11); respond(80, 1'b1, 2);
        coin_idle(25); select(12); respond(80, 1'b1, 1);

        // saturation, prepaid dispense, selection ignored during PAY
        coin_idle(200); coin_idle(100);
        select(21); respond(250, 1'b0, 2);
        select(33); respond(200, 1'b0, 1);
        pay_step(0, 1'b0, 1'b1); pay_step(100, 1'b0, 1'b1); pay_step(100, 1'b0, 1'b0);

        // reset while dispensing
        coin_idle(100); select(7);
        bus.price_valid = 1'b1; bus.price_data = AW'(50);
        tick();
        bus.price_valid = 1'b0;
        tick();
        chk("pre_reset_dispense", 32'(bus.dispense_valid), 1);
        rst = 1'b1;
        #1;
        chk("reset_dispense_valid", 32'(bus.dispense_valid), 0);
        chk("reset_dispense_item", 32'(bus.dispense_item), 0);
        chk("reset_change_valid", 32'(bus.change_valid), 0);
        chk("reset_change_amount", 32'(bus.change_amount), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_credit", 32'(bus.credit), 0);
        tick();
        rst = 1'b0;
        exp_credit = 0;
        tick();

`ifdef VEND_TIMEOUT_EN
        select(40); respond(200, 1'b0, 1); pay_step(100, 1'b0, 1'b0);
        for (int i = 1; i <= int'(TO); i++) begin
            tick();
            chk("timeout_evt", 32'(bus.timeout_evt), (i == int'(TO)) ? 1 : 0);
        end
        chk("timeout_refund_valid", 32'(bus.change_valid), 1);
        chk("timeout_refund_amount", 32'(bus.change_amount), 100);
        tick();
        chk("timeout_evt_pulse", 32'(bus.timeout_evt), 0);
        ack_change(100);

        select(41); respond(200, 1'b0, 1); pay_step(100, 1'b0, 1'b0);
        repeat (9) begin
            tick();
            chk("timeout_before_restart", 32'(bus.timeout_evt), 0);
        end
        pay_step(50, 1'b0, 1'b0);
        for (int i = 1; i <= int'(TO); i++) begin
            tick();
            chk("timeout_restart_evt", 32'(bus.timeout_evt), (i == int'(TO)) ? 1 : 0);
        end
        chk("timeout_restart_refund", 32'(bus.change_amount), 150);
        ack_change(150);
`endif

        for (int t = 0; t < 40; t++) random_txn();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
